// File: rtl/cpu_pkg.sv
//------------------------------------------------------------------------------
// Module  : cpu_pkg
// Brief   : Shared MIPS core definitions: opcodes, stage states, widths.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

    localparam int c_data_w = 32;
    localparam int c_reg_w  = 5;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_nop   = 6'b111111;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } stage_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_wb_reg.sv
//------------------------------------------------------------------------------
// Module  : mem_wb_reg
// Brief   : MEM/WB pipeline register; loads on enable, otherwise inserts a bubble.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_wb_reg
    import cpu_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int REG_W  = c_reg_w
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              nxt_valid,
    input  logic              nxt_reg_write,
    input  logic              nxt_mem_to_reg,
    input  logic [REG_W-1:0]  nxt_dest_reg,
    input  logic [DATA_W-1:0] nxt_alu_result,
    input  logic [DATA_W-1:0] nxt_load_data,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [REG_W-1:0]  wb_dest_reg,
    output logic [DATA_W-1:0] wb_alu_result,
    output logic [DATA_W-1:0] wb_load_data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_dest_reg   <= '0;
            wb_alu_result <= '0;
            wb_load_data  <= '0;
        end else if (load) begin
            wb_valid      <= nxt_valid;
            wb_reg_write  <= nxt_reg_write;
            wb_mem_to_reg <= nxt_mem_to_reg;
            wb_dest_reg   <= nxt_dest_reg;
            wb_alu_result <= nxt_alu_result;
            wb_load_data  <= nxt_load_data;
        end else begin
            // Bubble: only the qualifiers are cleared, data fields hold.
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ex_mem_access_stage.sv
//------------------------------------------------------------------------------
// Module  : ex_mem_access_stage
// Brief   : EX/MEM register, branch resolve and data-memory handshake stage.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ex_mem_access_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W  = c_data_w,
    parameter int REG_W   = c_reg_w,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_branch,
    input  logic              ex_bne,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_reg_write,
    input  logic              ex_mem_to_reg,
    input  logic              ex_zero,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [DATA_W-1:0] ex_branch_target,
    input  logic [REG_W-1:0]  ex_dest_reg,
    input  logic              flush,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall_out,
    output logic              pc_src,
    output logic [DATA_W-1:0] branch_target,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [REG_W-1:0]  wb_dest_reg,
    output logic [DATA_W-1:0] wb_alu_result,
    output logic [DATA_W-1:0] wb_load_data,
    output logic              mem_err
);

    localparam int              CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT - 1);

    stage_state_t      r_state;
    stage_state_t      w_state_nxt;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]  w_wait_cnt_nxt;
    logic              r_mem_err;

    logic              r_mem_valid;
    logic              r_branch;
    logic              r_bne;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_reg_write;
    logic              r_mem_to_reg;
    logic              r_zero;
    logic [DATA_W-1:0] r_alu_result;
    logic [DATA_W-1:0] r_store_data;
    logic [DATA_W-1:0] r_branch_target;
    logic [REG_W-1:0]  r_dest_reg;

    logic              w_in_wait;
    logic              w_stall;
    logic              w_ex_valid;
    logic              w_cap_mem;
    logic              w_timeout;
    logic              w_ack_done;
    logic              w_wb_load;
    logic [DATA_W-1:0] w_load_data;

    assign w_in_wait  = (r_state == S_WAIT);
    assign w_stall    = w_in_wait & ~dmem_ack;
    assign w_ex_valid = ex_valid & ~flush;
    assign w_cap_mem  = w_ex_valid & (ex_mem_read | ex_mem_write);
    assign w_ack_done = w_in_wait & dmem_ack;
    // Ack on the final wait cycle takes priority over the abort.
    assign w_timeout  = w_stall & (r_wait_cnt == c_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_timeout) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            S_IDLE: begin
                w_wait_cnt_nxt = '0;
                w_state_nxt    = w_cap_mem ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (dmem_ack) begin
                    // Back-to-back memory ops re-enter the wait directly.
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = w_cap_mem ? S_WAIT : S_IDLE;
                end else if (w_timeout) begin
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_wait_cnt_nxt = '0;
                w_state_nxt    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_valid     <= 1'b0;
            r_branch        <= 1'b0;
            r_bne           <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_reg_write     <= 1'b0;
            r_mem_to_reg    <= 1'b0;
            r_zero          <= 1'b0;
            r_alu_result    <= '0;
            r_store_data    <= '0;
            r_branch_target <= '0;
            r_dest_reg      <= '0;
        end else if (!w_stall) begin
            r_mem_valid     <= w_ex_valid;
            r_branch        <= ex_branch;
            r_bne           <= ex_bne;
            r_mem_read      <= ex_mem_read;
            r_mem_write     <= ex_mem_write;
            r_reg_write     <= ex_reg_write;
            r_mem_to_reg    <= ex_mem_to_reg;
            r_zero          <= ex_zero;
            r_alu_result    <= ex_alu_result;
            r_store_data    <= ex_store_data;
            r_branch_target <= ex_branch_target;
            r_dest_reg      <= ex_dest_reg;
        end
    end

    // In S_IDLE a resident memory op has already been retired (by abort), so
    // only non-memory instructions retire from there.
    assign w_wb_load   = w_ack_done | w_timeout |
                         (~w_in_wait & r_mem_valid & ~(r_mem_read | r_mem_write));
    assign w_load_data = (w_ack_done & r_mem_read) ? dmem_rdata : '0;

    mem_wb_reg #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_mem_wb_reg (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (w_wb_load),
        .nxt_valid      (r_mem_valid),
        .nxt_reg_write  (r_reg_write & ~w_timeout),
        .nxt_mem_to_reg (r_mem_to_reg),
        .nxt_dest_reg   (r_dest_reg),
        .nxt_alu_result (r_alu_result),
        .nxt_load_data  (w_load_data),
        .wb_valid       (wb_valid),
        .wb_reg_write   (wb_reg_write),
        .wb_mem_to_reg  (wb_mem_to_reg),
        .wb_dest_reg    (wb_dest_reg),
        .wb_alu_result  (wb_alu_result),
        .wb_load_data   (wb_load_data)
    );

    assign dmem_req      = w_in_wait;
    assign dmem_we       = w_in_wait & r_mem_write;
    assign dmem_addr     = r_alu_result;
    assign dmem_wdata    = r_store_data;
    assign stall_out     = w_stall;
    assign pc_src        = r_mem_valid & r_branch & (r_zero ^ r_bne);
    assign branch_target = r_branch_target;
    assign mem_err       = r_mem_err;

endmodule

`default_nettype wire
